// File: rtl/slideshow_fetch_ctrl_if.sv
// Bus between the VGA timing generator, the image ROM and slideshow_fetch_ctrl.
// master: the surrounding system (timing generator, buttons, ROM read data).
// slave:  the fetch controller itself.
interface slideshow_fetch_ctrl_if;
   // Frame sequencing controls
   logic        frame_start;
   logic        btn_next;
   logic        btn_prev;
   logic        pause;
   // Pixel request from the timing generator
   logic        pix_req;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;
   // ROM side
   logic [7:0]  rom_data;
   logic [2:0]  image_id;
   logic [14:0] rom_addr;
   // Pixel result and debug
   logic        pix_valid;
   logic        pix_on;
   logic [7:0]  hold_cnt;

   modport master (
      output frame_start,
      output btn_next,
      output btn_prev,
      output pause,
      output pix_req,
      output pix_x,
      output pix_y,
      output rom_data,
      input  image_id,
      input  rom_addr,
      input  pix_valid,
      input  pix_on,
      input  hold_cnt
   );

   modport slave (
      input  frame_start,
      input  btn_next,
      input  btn_prev,
      input  pause,
      input  pix_req,
      input  pix_x,
      input  pix_y,
      input  rom_data,
      output image_id,
      output rom_addr,
      output pix_valid,
      output pix_on,
      output hold_cnt
   );
endinterface

// File: rtl/slideshow_fetch_ctrl.sv
// Slideshow sequencer and pixel-fetch front end for a multi-image 1bpp ROM.
// Chooses the active image (auto-advance or button steps, only at frame
// boundaries), turns (x,y) pixel requests into ROM byte addresses and picks
// the addressed bit out of the returned byte after the ROM read latency.
module slideshow_fetch_ctrl #(
   parameter int unsigned NUM_IMAGES  = 5,
   parameter int unsigned HOLD_FRAMES = 120,
   parameter int unsigned IMG_W       = 240,
   parameter int unsigned IMG_H       = 160,
   parameter int unsigned ROM_LAT     = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   slideshow_fetch_ctrl_if.slave bus
);

   // Result pipeline covers the address register plus the ROM latency.
   localparam int unsigned Depth     = ROM_LAT + 1;
   localparam logic [2:0]  LastImage = 3'(NUM_IMAGES - 1);
   localparam logic [7:0]  HoldLast  = 8'(HOLD_FRAMES - 1);
   localparam logic [8:0]  ImgWLim   = 9'(IMG_W);
   localparam logic [8:0]  ImgHLim   = 9'(IMG_H);
   localparam logic [14:0] RowBytes  = 15'(IMG_W / 8);

   typedef enum logic [1:0] {
      StepNone = 2'b00,
      StepInc  = 2'b01,
      StepDec  = 2'b10
   } step_e;

   // ------------------------------------------------------------------
   // Image sequencing state
   // ------------------------------------------------------------------
   step_e      pending_q, pending_d;
   step_e      step_eff;
   logic [2:0] image_id_q, image_id_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [2:0] next_image;
   logic [2:0] prev_image;

   // ------------------------------------------------------------------
   // Pixel fetch state
   // ------------------------------------------------------------------
   logic              in_range;
   logic [14:0]       addr_calc;
   logic [14:0]       rom_addr_q, rom_addr_d;
   logic [Depth-1:0]  req_q, req_d;
   logic [Depth-1:0]  inr_q, inr_d;
   logic [Depth-1:0][2:0] idx_q, idx_d;
   logic [2:0]        sel_idx;

   // Resolve this cycle's button input against the pending step; a lone
   // press overrides, a simultaneous pair is ignored.
   always_comb begin
      step_eff = pending_q;
      if (bus.btn_next && !bus.btn_prev) begin
         step_eff = StepInc;
      end else if (bus.btn_prev && !bus.btn_next) begin
         step_eff = StepDec;
      end
   end

   // Wrap-around neighbours of the current image.
   always_comb begin
      next_image = (image_id_q == LastImage) ? 3'd0 : image_id_q + 3'd1;
      prev_image = (image_id_q == 3'd0) ? LastImage : image_id_q - 3'd1;
   end

   // Next-state for image selection: only frame_start may change image_id.
   always_comb begin
      pending_d  = step_eff;
      image_id_d = image_id_q;
      hold_cnt_d = hold_cnt_q;
      if (bus.frame_start) begin
         pending_d = StepNone;
         unique case (step_eff)
            StepInc: begin
               image_id_d = next_image;
               hold_cnt_d = 8'd0;
            end
            StepDec: begin
               image_id_d = prev_image;
               hold_cnt_d = 8'd0;
            end
            default: begin
               // Auto-advance path; pause freezes the counter entirely.
               if (!bus.pause) begin
                  if (hold_cnt_q == HoldLast) begin
                     image_id_d = next_image;
                     hold_cnt_d = 8'd0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 8'd1;
                  end
               end
            end
         endcase
      end
   end

   // Sequencing registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= StepNone;
         image_id_q <= 3'd0;
         hold_cnt_q <= 8'd0;
      end else begin
         pending_q  <= pending_d;
         image_id_q <= image_id_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Range check and byte address for the requested pixel.
   always_comb begin
      in_range  = ({1'b0, bus.pix_x} < ImgWLim) && ({1'b0, bus.pix_y} < ImgHLim);
      addr_calc = 15'(bus.pix_y) * RowBytes + 15'(bus.pix_x[7:3]);
      // Out-of-range requests leave the ROM address where it was.
      rom_addr_d = (bus.pix_req && in_range) ? addr_calc : rom_addr_q;
   end

   // Result pipeline: stage 0 lines up with rom_addr, the last stage with
   // rom_data. Side fields are zeroed for idle slots to keep them quiet.
   always_comb begin
      req_d    = '0;
      inr_d    = '0;
      idx_d    = '0;
      req_d[0] = bus.pix_req;
      inr_d[0] = bus.pix_req & in_range;
      idx_d[0] = bus.pix_req ? bus.pix_x[2:0] : 3'd0;
      for (int i = 1; i < Depth; i++) begin
         req_d[i] = req_q[i-1];
         inr_d[i] = inr_q[i-1];
         idx_d[i] = idx_q[i-1];
      end
   end

   // Address and pipeline registers; reset drops every in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q <= 15'd0;
         req_q      <= '0;
         inr_q      <= '0;
         idx_q      <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         req_q      <= req_d;
         inr_q      <= inr_d;
         idx_q      <= idx_d;
      end
   end

   // MSB-first bit select on the byte returned for the oldest request.
   always_comb begin
      sel_idx       = 3'd7 - idx_q[Depth-1];
      bus.pix_valid = req_q[Depth-1];
      bus.pix_on    = req_q[Depth-1] & inr_q[Depth-1] & bus.rom_data[sel_idx];
      bus.image_id  = image_id_q;
      bus.rom_addr  = rom_addr_q;
      bus.hold_cnt  = hold_cnt_q;
   end

endmodule

// File: tb/tb_slideshow_fetch_ctrl.sv
// Bench for slideshow_fetch_ctrl: table-driven frame sequencing vectors,
// hand-written pixel/reset sequences and a randomized run against a
// behavioural model of the slideshow and a 2-cycle ROM.
module tb_slideshow_fetch_ctrl;

   localparam int NumImages = 5;
   localparam int HoldFrames = 3;
   localparam int ImgW = 240;
   localparam int ImgH = 160;

   logic clk;
   logic rst_n;

   slideshow_fetch_ctrl_if bus ();

   slideshow_fetch_ctrl #(
      .NUM_IMAGES  (NumImages),
      .HOLD_FRAMES (HoldFrames),
      .IMG_W       (ImgW),
      .IMG_H       (ImgH),
      .ROM_LAT     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: fixed bytes at addresses 0 and 1, a hash elsewhere.
   function automatic logic [7:0] rom_byte(input logic [2:0] img, input logic [14:0] addr);
      if (addr == 15'd0) return 8'h80;
      if (addr == 15'd1) return 8'h40;
      return 8'(((32'(addr) * 32'd37) ^ (32'(img) * 32'd91)) ^ (32'(addr) >> 5));
   endfunction

   // Two-cycle ROM: address/image sampled, then a select register.
   logic [7:0] rom_r1;
   always @(posedge clk) begin
      rom_r1       <= rom_byte(bus.image_id, bus.rom_addr);
      bus.rom_data <= rom_r1;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // Reference model
   int m_img, m_hold, m_pend, m_addr;
   typedef struct {
      int   due;
      logic on;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic fs, bn, bp, pa;
      int   exp_id;
      int   exp_hold;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_img  = 0;
      m_hold = 0;
      m_pend = 0;
      m_addr = 0;
      exp_q.delete();
   endtask

   // Slideshow rules at frame granularity.
   task automatic model_frame(input logic fs, input logic bn, input logic bp, input logic pa);
      int step;
      step = m_pend;
      if (bn && !bp) step = 1;
      else if (bp && !bn) step = -1;
      if (fs) begin
         if (step != 0) begin
            m_img  = (m_img + step + NumImages) % NumImages;
            m_hold = 0;
         end else if (!pa) begin
            m_hold = m_hold + 1;
            if (m_hold == HoldFrames) begin
               m_hold = 0;
               m_img  = (m_img + 1) % NumImages;
            end
         end
         m_pend = 0;
      end else begin
         m_pend = step;
      end
   endtask

   // One clock: drive inputs, advance model, compare after the edge.
   task automatic cycle(input logic fs, input logic bn, input logic bp, input logic pa,
                        input logic rq, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      logic [7:0] b;
      logic exp_valid;
      logic exp_on;
      bus.frame_start = fs;
      bus.btn_next    = bn;
      bus.btn_prev    = bp;
      bus.pause       = pa;
      bus.pix_req     = rq;
      bus.pix_x       = x;
      bus.pix_y       = y;
      model_frame(fs, bn, bp, pa);
      if (rq) begin
         e.due = cyc + 3;
         e.on  = 1'b0;
         if (int'(x) < ImgW && int'(y) < ImgH) begin
            m_addr = int'(y) * (ImgW / 8) + int'(x) / 8;
            // The ROM reads this address with the image current next cycle.
            b    = rom_byte(3'(m_img), 15'(m_addr));
            e.on = b[7 - (int'(x) % 8)];
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_valid = 1'b0;
      exp_on    = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e         = exp_q.pop_front();
         exp_valid = 1'b1;
         exp_on    = e.on;
      end
      check("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
      check("pix_on", 32'(bus.pix_on), 32'(exp_on));
      check("image_id", 32'(bus.image_id), m_img);
      check("hold_cnt", 32'(bus.hold_cnt), m_hold);
      check("rom_addr", 32'(bus.rom_addr), m_addr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
      check({tag, "_pix_on"}, 32'(bus.pix_on), 0);
      check({tag, "_image_id"}, 32'(bus.image_id), 0);
      check({tag, "_hold_cnt"}, 32'(bus.hold_cnt), 0);
      check({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
   endtask

   task automatic add(input logic fs, input logic bn, input logic bp, input logic pa,
                      input int id, input int hold);
      vec_t v;
      v.fs = fs; v.bn = bn; v.bp = bp; v.pa = pa;
      v.exp_id = id; v.exp_hold = hold;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] b4799;
      logic       rpause;

      // Frame-sequencing vectors, HOLD_FRAMES=3, starting from reset.
      add(1, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 2); add(1, 0, 0, 0, 1, 0);
      add(1, 0, 0, 0, 1, 1); add(1, 0, 0, 0, 1, 2); add(1, 0, 0, 0, 2, 0);
      add(1, 0, 0, 0, 2, 1);
      add(0, 1, 1, 0, 2, 1); add(1, 0, 0, 0, 2, 2); add(1, 0, 0, 0, 3, 0);
      add(0, 1, 0, 0, 3, 0); add(0, 0, 1, 0, 3, 0); add(1, 0, 0, 0, 2, 0);
      add(1, 1, 0, 0, 3, 0); add(1, 0, 0, 0, 3, 1);
      for (int i = 0; i < 10; i++) add(1, 0, 0, 1, 3, 1);
      add(0, 1, 0, 1, 3, 1); add(1, 0, 0, 1, 4, 0); add(1, 0, 0, 1, 4, 0);
      add(0, 1, 0, 0, 4, 0); add(1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0); add(1, 0, 0, 0, 4, 0);
      add(1, 0, 0, 0, 4, 1); add(1, 0, 0, 0, 4, 2); add(1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 0); add(1, 0, 0, 0, 4, 0);

      // Reset
      bus.frame_start = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
      bus.pause = 1'b0; bus.pix_req = 1'b0; bus.pix_x = 8'd0; bus.pix_y = 8'd0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Three back-to-back requests
      cycle(0, 0, 0, 0, 1, 8'd0, 8'd0);
      check("t1_addr0", 32'(bus.rom_addr), 0);
      cycle(0, 0, 0, 0, 1, 8'd9, 8'd0);
      check("t1_addr1", 32'(bus.rom_addr), 1);
      cycle(0, 0, 0, 0, 1, 8'd239, 8'd159);
      check("t1_addr4799", 32'(bus.rom_addr), 4799);
      check("t1_on0", 32'({bus.pix_valid, bus.pix_on}), 32'b11);
      idle(1);
      check("t1_on1", 32'({bus.pix_valid, bus.pix_on}), 32'b11);
      idle(1);
      b4799 = rom_byte(3'd0, 15'd4799);
      check("t1_on2", 32'({bus.pix_valid, bus.pix_on}), 32'({1'b1, b4799[0]}));
      idle(1);
      check("t1_drain", 32'(bus.pix_valid), 0);

      // Frame sequencing table
      foreach (tbl[i]) begin
         cycle(tbl[i].fs, tbl[i].bn, tbl[i].bp, tbl[i].pa, 1'b0, 8'd0, 8'd0);
         check("tbl_image_id", 32'(bus.image_id), tbl[i].exp_id);
         check("tbl_hold_cnt", 32'(bus.hold_cnt), tbl[i].exp_hold);
      end

      // Out-of-range requests keep rom_addr and return pix_on=0
      cycle(0, 0, 0, 0, 1, 8'd16, 8'd3);
      check("oor_addr_set", 32'(bus.rom_addr), 92);
      cycle(0, 0, 0, 0, 1, 8'd240, 8'd5);
      check("oor_x_addr_hold", 32'(bus.rom_addr), 92);
      cycle(0, 0, 0, 0, 1, 8'd10, 8'd160);
      check("oor_y_addr_hold", 32'(bus.rom_addr), 92);
      idle(1);
      check("oor_x_valid", 32'({bus.pix_valid, bus.pix_on}), 32'b10);
      idle(1);
      check("oor_y_valid", 32'({bus.pix_valid, bus.pix_on}), 32'b10);
      idle(1);

      // Reset with two requests in flight
      cycle(1, 1, 0, 0, 1, 8'd100, 8'd50);
      cycle(0, 0, 0, 0, 1, 8'd101, 8'd51);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5);

      // Randomized run against the model
      rpause = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic fs, bn, bp, rq;
         if ($urandom_range(0, 49) == 0) rpause = ~rpause;
         fs = ($urandom_range(0, 19) == 0);
         bn = ($urandom_range(0, 29) == 0);
         bp = ($urandom_range(0, 29) == 0);
         rq = ($urandom_range(0, 9) < 7);
         cycle(fs, bn, bp, rpause, rq, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 175)));
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/slideshow_fetch_ctrl.md
Name: slideshow_fetch_ctrl

Overview:
Sequencer and pixel-fetch front end for the 5-image 240x160 1bpp multi-image ROM.
- Picks the active image_id and advances it automatically every HOLD_FRAMES frames, or on next/prev button pulses.
- image_id changes only at frame boundaries.
- Turns display pixel requests (x,y) into ROM byte addresses and extracts the addressed bit after the ROM's fixed read latency.
- Sits between the VGA timing generator and the image ROM block.

Parameters:
NUM_IMAGES, 5, number of images; image_id range 0..NUM_IMAGES-1
HOLD_FRAMES, 120, frames each image is shown before auto-advance (>=1)
IMG_W, 240, image width in pixels (multiple of 8)
IMG_H, 160, image height in pixels
ROM_LAT, 2, clocks from rom_addr to matching rom_data (ROM register + select register)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_start  input  1  single-cycle pulse, once per frame, during vertical blanking
btn_next  input  1  single-cycle pulse (pre-debounced): step to the next image
btn_prev  input  1  single-cycle pulse (pre-debounced): step to the previous image
pause  input  1  level; while high, auto-advance is frozen
pix_req  input  1  pixel fetch request this cycle
pix_x  input  8  pixel column, 0..IMG_W-1
pix_y  input  8  pixel row, 0..IMG_H-1
rom_data  input  8  byte from the ROM, ROM_LAT cycles after rom_addr
image_id  output  3  active image, to the ROM
rom_addr  output  15  byte address, to the ROM
pix_valid  output  1  pixel result valid
pix_on  output  1  pixel value (1 = foreground)
hold_cnt  output  8  frames elapsed on the current image (debug)

Behaviour:
- Reset (async, rst_n=0):
  - image_id=0, rom_addr=0, pix_valid=0, pix_on=0, hold_cnt=0.
  - Pending step cleared; pixel pipeline flushed.
- Pending step register, 2 bits: {none, +1, -1}.
  - btn_next sets +1; btn_prev sets -1.
  - A later press overrides an earlier one within the same frame. Presses do not accumulate.
  - btn_next and btn_prev high in the same cycle: both ignored, pending unchanged.
- Image update happens only on a cycle with frame_start=1. The new image_id is visible the next cycle. Priority order:
  1. Pending step, including a press in that same cycle: apply the step and set hold_cnt=0. The press takes effect even when pause=1.
  2. Otherwise, if pause=0 and hold_cnt==HOLD_FRAMES-1: image_id+1 and hold_cnt=0.
  3. Otherwise, if pause=0: hold_cnt+1.
  4. Otherwise (pause=1): hold_cnt holds.
  - The pending step is cleared on every frame_start.
- Wrap-around: +1 from NUM_IMAGES-1 goes to 0; -1 from 0 goes to NUM_IMAGES-1. image_id never leaves the range 0..NUM_IMAGES-1.
- Address generation is registered, 1 cycle. On pix_req=1 with an in-range pixel:
  - rom_addr <= pix_y*(IMG_W/8) + pix_x[7:3], i.e. y*30 + x/8 at the defaults.
  - Use 15-bit unsigned arithmetic with no truncation (maximum 4799).
- Out-of-range request (pix_x>=IMG_W or pix_y>=IMG_H):
  - rom_addr holds its value.
  - The request is still tracked and produces pix_valid=1, pix_on=0.
- Pixel pipeline: a valid shift pipeline ROM_LAT+1 deep carries {req, in_range, bit_idx=pix_x[2:0]}.
  - pix_valid pulses exactly ROM_LAT+1 cycles after pix_req (3 at default), one pulse per request.
  - Back-to-back requests on consecutive cycles are fully pipelined: one result per cycle, in order.
- Bit select is MSB-first: pix_on = in_range & rom_data[7-bit_idx]. pix_on=0 whenever pix_valid=0.
- Requests in flight when image_id changes return data from whichever image the ROM had sampled; no stall.
- No backpressure: the consumer must accept pix_valid whenever it is asserted.
- Reset mid-frame or mid-pipeline: all in-flight pix_valid are dropped. The first result after rst_n deasserts requires a fresh pix_req.

Test Plan:
1. Reset, then 3 back-to-back requests (x,y)=(0,0),(9,0),(239,159) -> rom_addr 0, 1, 4799 on successive cycles. pix_valid at +3,+4,+5. With rom_data model 8'h80 at addr 0 and 8'h40 at addr 1: pix_on 1, 1, then the value of bit0 of byte 4799.
2. HOLD_FRAMES=3, pause=0, 7 frame_start pulses -> image_id after each pulse: 0,0,1,1,1,2,2. hold_cnt wraps 0,1,2->0.
3. image_id=4, btn_next then frame_start -> image_id=0. Then btn_prev then frame_start -> image_id=4. hold_cnt=0 after each step.
4. btn_next and btn_prev in the same cycle -> no change at the next frame_start (auto counting only). btn_next then btn_prev in one frame -> image_id-1. btn_next coincident with frame_start -> applied at that edge.
5. pause=1 across 10 frames -> image_id and hold_cnt frozen. btn_next still steps image_id by 1.
6. Request at x=240, y=5 -> rom_addr unchanged, pix_valid after 3 cycles with pix_on=0. rst_n pulsed low while 2 requests are in flight -> no pix_valid after release, all outputs at reset values.
